// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - B-stream feeder and A-FIFO pop sequencer for a systolic MAC chain.
// Optional FEEDER_STALL_CNT_EN builds the B-stream bubble counter behind stall_cnt.
module mac_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_MAC    = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic                  b_valid,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  b_ready,
   input  logic [NUM_MAC-1:0]    a_empty,
   output logic [NUM_MAC-1:0]    a_rd_en,
   output logic                  en_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic                  clr_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           stall_cnt
);

   localparam int DCW = $clog2(NUM_MAC) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [LEN_WIDTH-1:0]    issue_q, issue_d;
   logic [DCW-1:0]          drain_q, drain_d;
   logic                    en_q, en_d;
   logic [DATA_WIDTH-1:0]   bout_q, bout_d;
   logic [NUM_MAC-2:0]      sr_q, sr_d;
   logic                    err_q, err_d;
   logic                    hs;
   logic [LEN_WIDTH-1:0]    issue_inc;

   // Stage i of the pop wave is en_out delayed i cycles, so bubbles travel with the data.
   assign a_rd_en = {sr_q, en_q};

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      issue_d   = issue_q;
      drain_d   = drain_q;
      err_d     = err_q;
      hs        = (state_q == S_FEED) && b_valid;
      issue_inc = issue_q + LEN_WIDTH'(1);
      en_d      = hs;
      bout_d    = hs ? b_data : bout_q;
      sr_d      = (state_q == S_CLEAR) ? '0 : a_rd_en[NUM_MAC-2:0];

      if (|(a_rd_en & a_empty)) begin
         err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = len;
               issue_d = '0;
               err_d   = 1'b0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            drain_d = '0;
            state_d = (len_q == '0) ? S_DONE : S_FEED;
         end
         S_FEED: begin
            if (hs) begin
               issue_d = issue_inc;
               if (issue_inc == len_q) begin
                  drain_d = '0;
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == DCW'(NUM_MAC - 1)) begin
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + DCW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         issue_q <= '0;
         drain_q <= '0;
         en_q    <= 1'b0;
         bout_q  <= '0;
         sr_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         issue_q <= issue_d;
         drain_q <= drain_d;
         en_q    <= en_d;
         bout_q  <= bout_d;
         sr_q    <= sr_d;
         err_q   <= err_d;
      end
   end

   assign b_ready = (state_q == S_FEED);
   assign clr_out = (state_q == S_CLEAR);
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign en_out  = en_q;
   assign b_out   = bout_q;
   assign err     = err_q;

`ifdef FEEDER_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == S_IDLE) && start) begin
         stall_d = '0;
      end else if ((state_q == S_FEED) && !b_valid && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - randomized self-checking bench for mac_feeder (NUM_MAC=4).
// Expected traces come from a cycle-indexed model of handshakes, latency and drain length.
module tb_mac_feeder;

   localparam int NM = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  len;
   logic        b_valid;
   logic [7:0]  b_data;
   logic        b_ready;
   logic [NM-1:0] a_empty;
   logic [NM-1:0] a_rd_en;
   logic        en_out;
   logic [7:0]  b_out;
   logic        clr_out;
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] last_bout_m = 8'h00;

   mac_feeder #(.DATA_WIDTH(8), .NUM_MAC(NM), .LEN_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .a_empty(a_empty), .a_rd_en(a_rd_en), .en_out(en_out), .b_out(b_out),
      .clr_out(clr_out), .busy(busy), .done(done), .err(err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [34:0] obs;
      rst_n = 1'b0; start = 1'b1; len = 8'd5; b_valid = 1'b1; b_data = 8'hFF; a_empty = '1;
      repeat (3) next_cycle();
      obs = {b_ready, a_rd_en, en_out, b_out, clr_out, busy, done, err, stall_cnt};
      n_cmp++;
      if (obs !== 35'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h expected 0", obs);
      end
      start = 1'b0; b_valid = 1'b0; b_data = 8'h00; a_empty = '0; len = 8'd0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release_busy: got %b expected 0", busy);
      end
      last_bout_m = 8'h00;
   endtask

   task automatic test_stream();
      bit         vp[0:79];
      logic [7:0] dat[0:15];
      bit         hs[0:79];
      int         kidx[0:79];
      logic [7:0] eb[0:79];
      bit         ebr[0:79];
      for (int tc = 0; tc < 9; tc++) begin
         int ln, k, lh, dn, est;
         logic [7:0] bo;
         logic [17:0] exp_v, obs_v;
         logic [NM-1:0] rdv;
         bit env;
         case (tc)
            0: ln = 3;
            1: ln = 3;
            2: ln = 0;
            default: ln = $urandom_range(1, 10);
         endcase
         for (int c = 0; c < 80; c++) begin
            if (tc == 0 || tc == 2) vp[c] = 1'b1;
            else if (tc == 1) vp[c] = (c != 3);
            else vp[c] = (c < 40) ? ($urandom_range(0, 9) < 7) : 1'b1;
         end
         for (int i = 0; i < 16; i++) begin
            dat[i] = (tc < 3) ? 8'(i + 1) : 8'($urandom_range(0, 255));
         end
         k = 0; lh = -1; bo = last_bout_m; est = 0;
         for (int c = 0; c < 80; c++) begin
            eb[c]   = bo;
            kidx[c] = k;
            ebr[c]  = (ln > 0) && (c >= 2) && (k < ln);
            hs[c]   = ebr[c] && vp[c];
            if (ebr[c] && !vp[c]) est++;
            if (hs[c]) begin
               bo = dat[k];
               k++;
               if (k == ln) lh = c;
            end
         end
         dn = (ln == 0) ? 2 : lh + NM + 1;
         for (int c = 0; c <= dn + 1; c++) begin
            env = (c >= 1) && hs[c-1];
            for (int i = 0; i < NM; i++) begin
               rdv[i] = (c - i >= 1) && hs[c-i-1];
            end
            exp_v = {ebr[c], env, eb[c], rdv, (c == 1), (c >= 1 && c <= dn), (c == dn), 1'b0};
            obs_v = {b_ready, en_out, b_out, a_rd_en, clr_out, busy, done, err};
            n_cmp++;
            if (obs_v !== exp_v) begin
               n_bad++;
               $display("FAIL stream case %0d cycle %0d len %0d: got %h expected %h", tc, c, ln, obs_v, exp_v);
            end
            start   = (c == 0);
            len     = 8'(ln);
            b_valid = vp[c];
            b_data  = dat[kidx[c]];
            next_cycle();
         end
         start = 1'b0; b_valid = 1'b0;
         last_bout_m = bo;
`ifndef FEEDER_STALL_CNT_EN
         est = 0;
`endif
         n_cmp++;
         if (stall_cnt !== 16'(est)) begin
            n_bad++;
            $display("FAIL stall_cnt case %0d: got %0d expected %0d", tc, stall_cnt, est);
         end
      end
   endtask

   task automatic test_underrun();
      for (int c = 0; c <= 10; c++) begin
         n_cmp++;
         if (err !== (c >= 6)) begin
            n_bad++;
            $display("FAIL underrun_err cycle %0d: got %b expected %b", c, err, (c >= 6));
         end
         if (c == 9) begin
            n_cmp++;
            if (done !== 1'b1) begin
               n_bad++;
               $display("FAIL underrun_done cycle 9: got %b expected 1", done);
            end
         end
         start   = (c == 0);
         len     = 8'd3;
         b_valid = 1'b1;
         b_data  = (c >= 2 && c <= 4) ? 8'(c - 1) : 8'h00;
         a_empty = (c <= 9) ? 4'b0100 : 4'b0000;
         next_cycle();
      end
      last_bout_m = 8'd3;
      for (int c = 0; c < 20; c++) begin
         if (c == 0 || c == 1) begin
            n_cmp++;
            if (err !== (c == 0)) begin
               n_bad++;
               $display("FAIL underrun_clear cycle %0d: got %b expected %b", c, err, (c == 0));
            end
         end
         if (c > 1 && !busy) break;
         if (c == 19) begin
            n_cmp++; n_bad++;
            $display("FAIL underrun_rerun_timeout: got busy expected idle");
         end
         start = (c == 0); len = 8'd1; b_valid = 1'b1; b_data = 8'h5A;
         next_cycle();
      end
      start = 1'b0; b_valid = 1'b0;
      last_bout_m = 8'h5A;
   endtask

   task automatic test_start_ignored();
      int en_n = 0;
      for (int c = 0; c <= 10; c++) begin
         n_cmp++;
         if (done !== (c == 9)) begin
            n_bad++;
            $display("FAIL ignored_start_done cycle %0d: got %b expected %b", c, done, (c == 9));
         end
         if (en_out) en_n++;
         start   = (c == 0) || (c >= 2 && c <= 8);
         len     = (c == 0) ? 8'd3 : 8'd7;
         b_valid = 1'b1;
         b_data  = (c >= 2 && c <= 4) ? 8'(c - 1) : 8'hEE;
         next_cycle();
         start = 1'b0;
      end
      b_valid = 1'b0;
      n_cmp++;
      if (en_n !== 3 || b_out !== 8'd3 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL ignored_start_result: got en=%0d b_out=%0d busy=%b expected en=3 b_out=3 busy=0", en_n, b_out, busy);
      end
      last_bout_m = 8'd3;
   endtask

   task automatic test_midrun_reset();
      logic [34:0] obs;
      bit saw_done = 1'b0;
      for (int c = 0; c < 3; c++) begin
         start = (c == 0); len = 8'd3; b_valid = 1'b1; b_data = 8'(c + 1);
         next_cycle();
      end
      rst_n = 1'b0;
      #1;
      obs = {b_ready, a_rd_en, en_out, b_out, clr_out, busy, done, err, stall_cnt};
      n_cmp++;
      if (obs !== 35'd0) begin
         n_bad++;
         $display("FAIL midrun_reset_outputs: got %h expected 0", obs);
      end
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         if (done) saw_done = 1'b1;
      end
      rst_n = 1'b1; start = 1'b0; b_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         if (done) saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done !== 1'b0) begin
         n_bad++;
         $display("FAIL midrun_reset_no_done: got %b expected 0", saw_done);
      end
      for (int c = 0; c <= 10; c++) begin
         n_cmp++;
         if (done !== (c == 8)) begin
            n_bad++;
            $display("FAIL midrun_rerun_done cycle %0d: got %b expected %b", c, done, (c == 8));
         end
         if (c == 4) begin
            n_cmp++;
            if (b_out !== 8'd9 || en_out !== 1'b1) begin
               n_bad++;
               $display("FAIL midrun_rerun_data: got b_out=%0d en=%b expected b_out=9 en=1", b_out, en_out);
            end
         end
         start   = (c == 0);
         len     = 8'd2;
         b_valid = 1'b1;
         b_data  = (c == 2) ? 8'd7 : 8'd9;
         next_cycle();
      end
      start = 1'b0; b_valid = 1'b0;
      last_bout_m = 8'd9;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len = 8'd0; b_valid = 1'b0; b_data = 8'd0; a_empty = '0;
      test_reset();
      test_stream();
      test_underrun();
      test_start_ignored();
      test_midrun_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of B/A elements.
REQ-002 SHALL have parameter NUM_MAC, default 8, number of MACs in the chain (≥2).
REQ-003 SHALL have parameter LEN_WIDTH, default 8, width of vector-length input.
REQ-004 SHALL have ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start pulse.
- len  in  LEN_WIDTH  element count K, sampled on start.
- b_valid  in  1  B-stream element valid.
- b_data  in  DATA_WIDTH  B-stream element.
- b_ready  out  1  feeder accepts B element.
- a_empty  in  NUM_MAC  per-MAC A-FIFO empty flags.
- a_rd_en  out  NUM_MAC  per-MAC A-FIFO pop strobes.
- en_out  out  1  enable into MAC0.
- b_out  out  DATA_WIDTH  B value into MAC0.
- clr_out  out  1  clear to all MACs.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky A-FIFO underrun flag.
- stall_cnt  out  16  B-stream bubble count (see Configuration).

Function
REQ-005 SHALL implement FSM states IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-006 IDLE: start=1 latches len, clears issue counter and err, moves to CLEAR; start in any other state is ignored.
REQ-007 CLEAR: lasts exactly one cycle with clr_out=1; moves to DONE if latched len=0, else to FEED.
REQ-008 FEED: b_ready=1; a handshake (b_valid & b_ready) increments the issue counter; the handshake bringing the count to len moves to DRAIN.
REQ-009 b_ready SHALL be 0 in every state except FEED.
REQ-010 en_out and b_out SHALL be registered: en_out is 1 in the cycle after a handshake and 0 otherwise; b_out takes b_data on a handshake and holds otherwise.
REQ-011 b_valid=0 in FEED SHALL produce a bubble (en_out=0 next cycle) with no loss or duplication of elements.
REQ-012 a_rd_en[0] SHALL equal en_out; for i≥1, a_rd_en[i] SHALL equal en_out delayed i cycles through an (NUM_MAC-1)-stage shift register, so bubbles stay aligned with the systolic B/enable wave.
REQ-013 DRAIN: lasts exactly NUM_MAC cycles, then moves to DONE.
REQ-014 DONE: asserts done=1 for exactly one cycle, then moves to IDLE; every MAC result is final in that cycle.
REQ-015 err SHALL set on any cycle with a_rd_en[i] & a_empty[i] for any i, hold until the next accepted start, and never clear otherwise.
REQ-016 clr_out=1 SHALL also clear the enable shift register.

Reset
REQ-017 rst_n=0 SHALL asynchronously force state IDLE, clear counters and shift register, and drive b_ready, a_rd_en, en_out, b_out, clr_out, busy, done, err and stall_cnt to 0.
REQ-018 Reset mid-operation SHALL abandon the operation with no done pulse; the next start after release SHALL run normally.

Configuration
REQ-019 With macro FEEDER_STALL_CNT_EN defined, stall_cnt SHALL increment, saturating at 16'hFFFF, on each FEED cycle with b_valid=0, and SHALL clear on an accepted start.
REQ-020 Without FEEDER_STALL_CNT_EN, stall_cnt SHALL be tied to 0 and no counter logic is built.

Verification (NUM_MAC=4; start sampled at cycle 0)
REQ-021 Reset check: hold rst_n=0 -> every output is 0, busy=0.
REQ-022 Continuous stream: len=3, b_valid=1, b_data=1,2,3 -> clr_out=1 in cycle 1; b_ready=1 in cycles 2-4; en_out=1 with b_out=1,2,3 in cycles 3-5; a_rd_en[3]=1 in cycles 6-8; done=1 in cycle 9.
REQ-023 Bubble: same as REQ-022 but b_valid=0 in cycle 3 -> en_out pattern 1,0,1,1 over cycles 3-6; b_out sequence still 1,2,3; done=1 in cycle 10; stall_cnt=1 with FEEDER_STALL_CNT_EN defined, 0 without.
REQ-024 Zero length: len=0 -> clr_out=1 in cycle 1, done=1 in cycle 2, en_out never asserted.
REQ-025 Underrun: a_empty[2]=1 while a_rd_en[2]=1 -> err=1 from the next cycle, held through done, cleared by the next start.
REQ-026 Mid-run reset: drop rst_n in cycle 3 of REQ-022 -> all outputs 0 immediately and no done; a new start with len=2 completes with done=1 in cycle 8 after start.
